// File: rtl/sctag_decc_errlog_ctl_if.sv
// Signal bundle between the data-ECC decode control / CSR / CPU-request
// path and the data-ECC error logger. The master side drives the c8 strobes,
// address, enables, CSR write and ack; the slave side is the logger itself.
interface sctag_decc_errlog_ctl_if #(
    parameter int ADDR_W = 36
);
    logic              decc_spcd_corr_err_c8;
    logic              decc_spcd_uncorr_err_c8;
    logic              decc_spcfb_corr_err_c8;
    logic              decc_spcfb_uncorr_err_c8;
    logic              decc_bscd_corr_err_c8;
    logic              decc_bscd_uncorr_err_c8;
    logic              decc_scrd_corr_err_c8;
    logic              decc_scrd_uncorr_err_c8;
    logic [ADDR_W-1:0] err_addr_c8;
    logic              error_ceen;
    logic              error_nceen;
    logic              csr_esr_wr_en;
    logic [7:0]        csr_esr_wr_data;
    logic              err_ack;
    logic [7:0]        errlog_esr;
    logic [ADDR_W-1:0] errlog_ear;
    logic              err_req;
    logic              err_req_uncorr;

    modport master (
        output decc_spcd_corr_err_c8, decc_spcd_uncorr_err_c8,
               decc_spcfb_corr_err_c8, decc_spcfb_uncorr_err_c8,
               decc_bscd_corr_err_c8, decc_bscd_uncorr_err_c8,
               decc_scrd_corr_err_c8, decc_scrd_uncorr_err_c8,
               err_addr_c8, error_ceen, error_nceen,
               csr_esr_wr_en, csr_esr_wr_data, err_ack,
        input  errlog_esr, errlog_ear, err_req, err_req_uncorr
    );

    modport slave (
        input  decc_spcd_corr_err_c8, decc_spcd_uncorr_err_c8,
               decc_spcfb_corr_err_c8, decc_spcfb_uncorr_err_c8,
               decc_bscd_corr_err_c8, decc_bscd_uncorr_err_c8,
               decc_scrd_corr_err_c8, decc_scrd_uncorr_err_c8,
               err_addr_c8, error_ceen, error_nceen,
               csr_esr_wr_en, csr_esr_wr_data, err_ack,
        output errlog_esr, errlog_ear, err_req, err_req_uncorr
    );
endinterface

// File: rtl/sctag_decc_errlog_ctl.sv
// L2 data-ECC error logger: captures c8 error strobes into the ESR/EAR,
// tracks multiple-error overflow, and raises a req/ack notification for
// disrupting (scrub and block-store-copy) errors.
module sctag_decc_errlog_ctl #(
    parameter int ADDR_W = 36
) (
    input  logic                    rclk,
    input  logic                    reset,
    sctag_decc_errlog_ctl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    logic [7:0]        esr_q, esr_nxt;
    logic [ADDR_W-1:0] ear_q;
    logic              dac_set, dau_set, dsc_set, dsu_set;
    logic              any_corr, any_uncorr;
    logic [7:0]        clr_mask;
    logic              cap_en, cap_fbe;
    logic              ev, ev_uncorr;

    state_t            state_q, state_nxt;
    logic              type_q, type_nxt;
    logic              pend_q, pend_nxt;
    logic              pend_uncorr_q, pend_uncorr_nxt;

    // Classify strobes, compute ESR next value and whether the EAR captures.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        dac_set    = bus.decc_spcd_corr_err_c8 | bus.decc_spcfb_corr_err_c8 | bus.decc_bscd_corr_err_c8;
        dau_set    = bus.decc_spcd_uncorr_err_c8 | bus.decc_spcfb_uncorr_err_c8 | bus.decc_bscd_uncorr_err_c8;
        dsc_set    = bus.decc_scrd_corr_err_c8;
        dsu_set    = bus.decc_scrd_uncorr_err_c8;
        any_corr   = dac_set | dsc_set;
        any_uncorr = dau_set | dsu_set;
        clr_mask   = bus.csr_esr_wr_en ? bus.csr_esr_wr_data : 8'h00;
        cap_en     = 1'b0;
        cap_fbe    = 1'b0;

        // Uncorrectable capture rule takes precedence when both classes arrive.
        if (any_uncorr) begin
            cap_en  = ~esr_q[1] & ~esr_q[3];
            cap_fbe = bus.decc_spcfb_uncorr_err_c8;
        end else if (any_corr) begin
            cap_en  = (esr_q[3:0] == 4'b0000);
            cap_fbe = bus.decc_spcfb_corr_err_c8;
        end

        // Clear first, then set, so a new strobe wins over a W1C of the same bit.
        esr_nxt    = esr_q & ~clr_mask;
        esr_nxt[0] = esr_nxt[0] | dac_set;
        esr_nxt[1] = esr_nxt[1] | dau_set;
        esr_nxt[2] = esr_nxt[2] | dsc_set;
        esr_nxt[3] = esr_nxt[3] | dsu_set;
        // Overflow looks only at bits present before this update.
        esr_nxt[4] = esr_nxt[4] | (any_corr & (esr_q[0] | esr_q[2]));
        esr_nxt[5] = esr_nxt[5] | (any_uncorr & (esr_q[1] | esr_q[3]));
        if (cap_en) begin
            esr_nxt[6] = cap_fbe;
        end
        esr_nxt[7] = 1'b0;

        ev_uncorr = bus.error_nceen & (bus.decc_bscd_uncorr_err_c8 | bus.decc_scrd_uncorr_err_c8);
        ev        = ev_uncorr
                  | (bus.error_ceen & (bus.decc_bscd_corr_err_c8 | bus.decc_scrd_corr_err_c8));
    end

    // ESR/EAR registers; EAR is only ever written by a capture.
    always_ff @(posedge rclk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            esr_q <= 8'h00;
            ear_q <= '0;
        end else begin
            esr_q <= esr_nxt;
            if (cap_en) begin
                ear_q <= bus.err_addr_c8;
            end
        end
    end

    // Notification FSM next state, request type and pending-event bookkeeping.
    always_comb begin
        state_nxt       = state_q;
        type_nxt        = type_q;
        pend_nxt        = pend_q;
        pend_uncorr_nxt = pend_uncorr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ev) begin
                    state_nxt = ST_REQ;
                    type_nxt  = ev_uncorr;
                end
            end
            ST_REQ: begin
                if (ev) begin
                    pend_nxt        = 1'b1;
                    pend_uncorr_nxt = pend_uncorr_q | ev_uncorr;
                end
                if (bus.err_ack) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                // An event landing in the gap merges with anything already pending.
                if (pend_q | ev) begin
                    state_nxt = ST_REQ;
                    type_nxt  = (pend_q & pend_uncorr_q) | ev_uncorr;
                end else begin
                    state_nxt = ST_IDLE;
                end
                pend_nxt        = 1'b0;
                pend_uncorr_nxt = 1'b0;
            end
            default: begin
                state_nxt       = ST_IDLE;
                pend_nxt        = 1'b0;
                pend_uncorr_nxt = 1'b0;
            end
        endcase
    end

    // Notification FSM state register.
    always_ff @(posedge rclk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            type_q        <= 1'b0;
            pend_q        <= 1'b0;
            pend_uncorr_q <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            type_q        <= type_nxt;
            pend_q        <= pend_nxt;
            pend_uncorr_q <= pend_uncorr_nxt;
        end
    end

    assign bus.errlog_esr     = esr_q;
    assign bus.errlog_ear     = ear_q;
    assign bus.err_req        = (state_q == ST_REQ);
    assign bus.err_req_uncorr = (state_q == ST_REQ) & type_q;

endmodule

// File: tb/tb_sctag_decc_errlog_ctl.sv
// Bench for the data-ECC error logger: directed scenarios plus randomized
// traffic compared against a request-queue reference model.
module tb_sctag_decc_errlog_ctl;

    localparam int ADDR_W = 36;

    logic rclk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    sctag_decc_errlog_ctl_if #(.ADDR_W(ADDR_W)) bus ();

    sctag_decc_errlog_ctl #(.ADDR_W(ADDR_W)) dut (
        .rclk  (rclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 rclk = ~rclk;

    // Reference model: ESR/EAR values plus a queue of outstanding requests.
    // m_q[0] is the request being shown (unless in the gap cycle), m_q[1] is
    // a merged pending request.
    logic [7:0]        m_esr;
    logic [ADDR_W-1:0] m_ear;
    bit                m_q[$];
    bit                m_gap;

    task automatic model_clock();
        logic [7:0] e;
        logic c_da, u_da, c_sc, u_sc, cap, fb, ev, evu;
        if (reset) begin
            m_esr = 8'h00;
            m_ear = '0;
            m_q.delete();
            m_gap = 1'b0;
            return;
        end
        e    = m_esr;
        c_da = bus.decc_spcd_corr_err_c8 || bus.decc_spcfb_corr_err_c8 || bus.decc_bscd_corr_err_c8;
        u_da = bus.decc_spcd_uncorr_err_c8 || bus.decc_spcfb_uncorr_err_c8 || bus.decc_bscd_uncorr_err_c8;
        c_sc = bus.decc_scrd_corr_err_c8;
        u_sc = bus.decc_scrd_uncorr_err_c8;
        m_esr = bus.csr_esr_wr_en ? (e & ~bus.csr_esr_wr_data) : e;
        if (c_da) m_esr[0] = 1'b1;
        if (u_da) m_esr[1] = 1'b1;
        if (c_sc) m_esr[2] = 1'b1;
        if (u_sc) m_esr[3] = 1'b1;
        if ((c_da || c_sc) && (e[0] || e[2])) m_esr[4] = 1'b1;
        if ((u_da || u_sc) && (e[1] || e[3])) m_esr[5] = 1'b1;
        cap = 1'b0;
        fb  = 1'b0;
        if (u_da || u_sc) begin
            cap = (e[1] == 1'b0) && (e[3] == 1'b0);
            fb  = bus.decc_spcfb_uncorr_err_c8;
        end else if (c_da || c_sc) begin
            cap = (e[3:0] == 4'h0);
            fb  = bus.decc_spcfb_corr_err_c8;
        end
        if (cap) begin
            m_ear    = bus.err_addr_c8;
            m_esr[6] = fb;
        end
        m_esr[7] = 1'b0;

        evu = bus.error_nceen && (bus.decc_bscd_uncorr_err_c8 || bus.decc_scrd_uncorr_err_c8);
        ev  = evu || (bus.error_ceen && (bus.decc_bscd_corr_err_c8 || bus.decc_scrd_corr_err_c8));
        if (m_gap) begin
            m_gap = 1'b0;
            if (ev) begin
                if (m_q.size() == 0) m_q.push_back(evu);
                else m_q[0] = m_q[0] | evu;
            end
        end else if (m_q.size() == 0) begin
            if (ev) m_q.push_back(evu);
        end else begin
            if (ev) begin
                if (m_q.size() == 1) m_q.push_back(evu);
                else m_q[1] = m_q[1] | evu;
            end
            if (bus.err_ack) begin
                void'(m_q.pop_front());
                m_gap = 1'b1;
            end
        end
    endtask

    function automatic logic m_req();
        return !m_gap && (m_q.size() > 0);
    endfunction

    function automatic logic m_req_uncorr();
        return m_req() && m_q[0];
    endfunction

    task automatic clear_strobes();
        bus.decc_spcd_corr_err_c8    = 1'b0;
        bus.decc_spcd_uncorr_err_c8  = 1'b0;
        bus.decc_spcfb_corr_err_c8   = 1'b0;
        bus.decc_spcfb_uncorr_err_c8 = 1'b0;
        bus.decc_bscd_corr_err_c8    = 1'b0;
        bus.decc_bscd_uncorr_err_c8  = 1'b0;
        bus.decc_scrd_corr_err_c8    = 1'b0;
        bus.decc_scrd_uncorr_err_c8  = 1'b0;
        bus.csr_esr_wr_en            = 1'b0;
        bus.csr_esr_wr_data          = 8'h00;
        bus.err_ack                  = 1'b0;
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge rclk);
        model_clock();
        #1;
        clear_strobes();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (bus.errlog_esr !== 8'h00) $display("FAIL reset_esr got %h want 00", bus.errlog_esr); else passed++;
        total++; if (bus.errlog_ear !== '0) $display("FAIL reset_ear got %h want 0", bus.errlog_ear); else passed++;
        total++; if (bus.err_req !== 1'b0) $display("FAIL reset_req got %b want 0", bus.err_req); else passed++;
        total++; if (bus.err_req_uncorr !== 1'b0) $display("FAIL reset_req_uncorr got %b want 0", bus.err_req_uncorr); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_scrub_notify();
        do_reset();
        bus.error_ceen = 1'b1;
        bus.error_nceen = 1'b0;
        bus.decc_scrd_corr_err_c8 = 1'b1;
        bus.err_addr_c8 = 36'h1234;
        tick();
        total++; if (bus.errlog_esr !== 8'h04) $display("FAIL scrub_esr got %h want 04", bus.errlog_esr); else passed++;
        total++; if (bus.errlog_ear !== 36'h1234) $display("FAIL scrub_ear got %h want 1234", bus.errlog_ear); else passed++;
        total++; if (bus.err_req !== 1'b1) $display("FAIL scrub_req got %b want 1", bus.err_req); else passed++;
        total++; if (bus.err_req_uncorr !== 1'b0) $display("FAIL scrub_type got %b want 0", bus.err_req_uncorr); else passed++;
        bus.err_ack = 1'b1;
        tick();
        total++; if (bus.err_req !== 1'b0) $display("FAIL scrub_gap got %b want 0", bus.err_req); else passed++;
        tick();
        total++; if (bus.err_req !== 1'b0) $display("FAIL scrub_idle got %b want 0", bus.err_req); else passed++;
        tick();
        total++; if (bus.err_req !== 1'b0) $display("FAIL scrub_idle2 got %b want 0", bus.err_req); else passed++;
    endtask

    task automatic test_multi_error();
        do_reset();
        bus.error_ceen = 1'b1;
        bus.error_nceen = 1'b1;
        bus.decc_spcd_corr_err_c8 = 1'b1;
        bus.err_addr_c8 = 36'hA_AAAA_0001;
        tick();
        total++; if (bus.err_req !== 1'b0) $display("FAIL multi_req1 got %b want 0", bus.err_req); else passed++;
        bus.decc_spcd_uncorr_err_c8 = 1'b1;
        bus.err_addr_c8 = 36'hB_BBBB_0002;
        tick();
        total++; if (bus.errlog_esr !== 8'h03) $display("FAIL multi_esr_mid got %h want 03", bus.errlog_esr); else passed++;
        total++; if (bus.err_req !== 1'b0) $display("FAIL multi_req2 got %b want 0", bus.err_req); else passed++;
        bus.decc_spcd_uncorr_err_c8 = 1'b1;
        bus.err_addr_c8 = 36'hC_CCCC_0003;
        tick();
        total++; if (bus.errlog_esr !== 8'h23) $display("FAIL multi_esr got %h want 23", bus.errlog_esr); else passed++;
        total++; if (bus.errlog_ear !== 36'hB_BBBB_0002) $display("FAIL multi_ear got %h want BBBBB0002", bus.errlog_ear); else passed++;
        total++; if (bus.err_req !== 1'b0) $display("FAIL multi_req3 got %b want 0", bus.err_req); else passed++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        bus.error_ceen = 1'b1;
        bus.error_nceen = 1'b1;
        bus.decc_spcfb_corr_err_c8 = 1'b1;
        bus.decc_scrd_uncorr_err_c8 = 1'b1;
        bus.err_addr_c8 = 36'h0_CAFE_00C0;
        tick();
        total++; if (bus.errlog_esr !== 8'h09) $display("FAIL same_esr got %h want 09", bus.errlog_esr); else passed++;
        total++; if (bus.errlog_ear !== 36'h0_CAFE_00C0) $display("FAIL same_ear got %h want 0CAFE00C0", bus.errlog_ear); else passed++;
        total++; if (bus.err_req !== 1'b1) $display("FAIL same_req got %b want 1", bus.err_req); else passed++;
        total++; if (bus.err_req_uncorr !== 1'b1) $display("FAIL same_type got %b want 1", bus.err_req_uncorr); else passed++;
        bus.err_ack = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.error_ceen = 1'b1;
        bus.error_nceen = 1'b1;
        bus.decc_bscd_corr_err_c8 = 1'b1;
        tick();
        total++; if (bus.err_req !== 1'b1 || bus.err_req_uncorr !== 1'b0)
            $display("FAIL b2b_first got %b/%b want 1/0", bus.err_req, bus.err_req_uncorr); else passed++;
        bus.decc_bscd_uncorr_err_c8 = 1'b1;
        tick();
        total++; if (bus.err_req !== 1'b1 || bus.err_req_uncorr !== 1'b0)
            $display("FAIL b2b_hold got %b/%b want 1/0", bus.err_req, bus.err_req_uncorr); else passed++;
        bus.err_ack = 1'b1;
        tick();
        total++; if (bus.err_req !== 1'b0) $display("FAIL b2b_gap got %b want 0", bus.err_req); else passed++;
        tick();
        total++; if (bus.err_req !== 1'b1 || bus.err_req_uncorr !== 1'b1)
            $display("FAIL b2b_second got %b/%b want 1/1", bus.err_req, bus.err_req_uncorr); else passed++;
        bus.err_ack = 1'b1;
        tick();
        total++; if (bus.err_req !== 1'b0) $display("FAIL b2b_gap2 got %b want 0", bus.err_req); else passed++;
        tick();
        total++; if (bus.err_req !== 1'b0) $display("FAIL b2b_idle got %b want 0", bus.err_req); else passed++;
        tick();
        total++; if (bus.err_req !== 1'b0) $display("FAIL b2b_idle2 got %b want 0", bus.err_req); else passed++;
    endtask

    task automatic test_w1c_set_wins();
        do_reset();
        bus.error_ceen = 1'b0;
        bus.error_nceen = 1'b0;
        bus.decc_spcd_corr_err_c8 = 1'b1;
        bus.decc_scrd_corr_err_c8 = 1'b1;
        bus.err_addr_c8 = 36'h5_0000_0055;
        tick();
        total++; if (bus.errlog_esr !== 8'h05) $display("FAIL w1c_pre got %h want 05", bus.errlog_esr); else passed++;
        bus.csr_esr_wr_en = 1'b1;
        bus.csr_esr_wr_data = 8'h05;
        bus.decc_scrd_corr_err_c8 = 1'b1;
        bus.err_addr_c8 = 36'h6_0000_0066;
        tick();
        total++; if (bus.errlog_esr !== 8'h14) $display("FAIL w1c_esr got %h want 14", bus.errlog_esr); else passed++;
        total++; if (bus.errlog_ear !== 36'h5_0000_0055) $display("FAIL w1c_ear got %h want 500000055", bus.errlog_ear); else passed++;
        total++; if (bus.err_req !== 1'b0) $display("FAIL w1c_req got %b want 0", bus.err_req); else passed++;
        bus.csr_esr_wr_en = 1'b1;
        bus.csr_esr_wr_data = 8'hFF;
        tick();
        total++; if (bus.errlog_esr !== 8'h00) $display("FAIL w1c_all got %h want 00", bus.errlog_esr); else passed++;
        total++; if (bus.errlog_ear !== 36'h5_0000_0055) $display("FAIL w1c_ear_kept got %h want 500000055", bus.errlog_ear); else passed++;
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        bus.error_ceen = 1'b1;
        bus.error_nceen = 1'b1;
        bus.decc_scrd_corr_err_c8 = 1'b1;
        bus.err_addr_c8 = 36'h7_7777_7777;
        tick();
        bus.decc_scrd_uncorr_err_c8 = 1'b1;
        tick();
        total++; if (bus.err_req !== 1'b1) $display("FAIL rmid_req got %b want 1", bus.err_req); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (bus.err_req !== 1'b0 || bus.err_req_uncorr !== 1'b0)
            $display("FAIL rmid_drop got %b/%b want 0/0", bus.err_req, bus.err_req_uncorr); else passed++;
        total++; if (bus.errlog_esr !== 8'h00 || bus.errlog_ear !== '0)
            $display("FAIL rmid_regs got %h/%h want 00/0", bus.errlog_esr, bus.errlog_ear); else passed++;
        for (int i = 0; i < 4; i++) begin
            bus.err_ack = 1'b1;
            tick();
            total++; if (bus.err_req !== 1'b0) $display("FAIL rmid_quiet%0d got %b want 0", i, bus.err_req); else passed++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.decc_spcd_corr_err_c8    = ($urandom_range(0, 9) == 0);
            bus.decc_spcd_uncorr_err_c8  = ($urandom_range(0, 11) == 0);
            bus.decc_spcfb_corr_err_c8   = ($urandom_range(0, 11) == 0);
            bus.decc_spcfb_uncorr_err_c8 = ($urandom_range(0, 13) == 0);
            bus.decc_bscd_corr_err_c8    = ($urandom_range(0, 7) == 0);
            bus.decc_bscd_uncorr_err_c8  = ($urandom_range(0, 9) == 0);
            bus.decc_scrd_corr_err_c8    = ($urandom_range(0, 7) == 0);
            bus.decc_scrd_uncorr_err_c8  = ($urandom_range(0, 9) == 0);
            bus.err_addr_c8              = {4'($urandom), 32'($urandom)};
            bus.error_ceen               = ($urandom_range(0, 3) != 0);
            bus.error_nceen              = ($urandom_range(0, 3) != 0);
            bus.csr_esr_wr_en            = ($urandom_range(0, 5) == 0);
            bus.csr_esr_wr_data          = 8'($urandom);
            bus.err_ack                  = ($urandom_range(0, 2) == 0);
            reset                        = ($urandom_range(0, 149) == 0);
            tick();
            reset = 1'b0;
            total++; if (bus.errlog_esr !== m_esr)
                $display("FAIL rand_esr cyc %0d got %h want %h", i, bus.errlog_esr, m_esr); else passed++;
            total++; if (bus.errlog_ear !== m_ear)
                $display("FAIL rand_ear cyc %0d got %h want %h", i, bus.errlog_ear, m_ear); else passed++;
            total++; if (bus.err_req !== m_req())
                $display("FAIL rand_req cyc %0d got %b want %b", i, bus.err_req, m_req()); else passed++;
            total++; if (bus.err_req_uncorr !== m_req_uncorr())
                $display("FAIL rand_type cyc %0d got %b want %b", i, bus.err_req_uncorr, m_req_uncorr()); else passed++;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.error_ceen  = 1'b0;
        bus.error_nceen = 1'b0;
        bus.err_addr_c8 = '0;
        clear_strobes();
        m_esr = 8'h00;
        m_ear = '0;
        m_gap = 1'b0;
        #1;
        test_reset();
        test_scrub_notify();
        test_multi_error();
        test_same_cycle();
        test_back_to_back();
        test_w1c_set_wins();
        test_reset_mid_req();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sctag_decc_errlog_ctl.md
# sctag_decc_errlog_ctl

Consumer of the L2 data-ECC error classification strobes. It sits in the sctag downstream of the data-ECC decode control. It captures the c8 error strobes and the failing address into an error status register (ESR) and error address register (EAR). It tracks multiple-error overflow. It raises a req/ack notification toward the CPU-request path for disrupting errors, meaning scrub and BSC errors; precise SPARC errors are already returned with the read data.

## Interface
Parameters:
- `ADDR_W`, default 36: width of captured address, PA[39:4].

Ports:
- `rclk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `decc_spcd_corr_err_c8`, `decc_spcd_uncorr_err_c8` in 1 each: SPARC read data error strobes, corrected / uncorrected.
- `decc_spcfb_corr_err_c8`, `decc_spcfb_uncorr_err_c8` in 1 each: SPARC read from the fill buffer.
- `decc_bscd_corr_err_c8`, `decc_bscd_uncorr_err_c8` in 1 each: block-store-copy read.
- `decc_scrd_corr_err_c8`, `decc_scrd_uncorr_err_c8` in 1 each: scrub read.
- `err_addr_c8` in ADDR_W: address of the access in c8.
- `error_ceen`, `error_nceen` in 1 each: notification enables for correctable / uncorrectable errors.
- `csr_esr_wr_en` in 1: CSR write strobe to the ESR.
- `csr_esr_wr_data` in 8: write-1-to-clear mask.
- `err_ack` in 1: acknowledge from the CPU-request path.
- `errlog_esr` out 8: ESR bits.
- `errlog_ear` out ADDR_W: EAR.
- `err_req` out 1: notification request.
- `err_req_uncorr` out 1: request type; 1 means uncorrectable.

## Operation
ESR bits:
- [0] DAC: correctable on spcd, spcfb or bscd.
- [1] DAU: uncorrectable on spcd, spcfb or bscd.
- [2] DSC: scrub correctable.
- [3] DSU: scrub uncorrectable.
- [4] MEC: a correctable error arrived while DAC or DSC was already set.
- [5] MEU: an uncorrectable error arrived while DAU or DSU was already set.
- [6] FBE: the last captured error came from the fill buffer.
- [7] reserved, reads 0.

Set and clear rules:
- Valid bits are sticky.
- MEC/MEU are set only against pre-existing bits. Two simultaneous new strobes of the same class do not set ME.
- A CSR W1C clears the masked bits.
- Set wins over clear when both hit the same bit in the same cycle.
- EAR is never cleared by CSR.

EAR capture:
- Capture `err_addr_c8` on any uncorrectable strobe when DAU=DSU=0 before the update. The uncorrectable address overwrites an address captured for a correctable error.
- Capture on a correctable strobe only when all of [3:0] are 0 before the update.
- When uncorrectable and correctable strobes arrive together, the uncorrectable rule applies.
- FBE follows the strobe that caused the capture.

Disrupting event:
- Any bscd or scrd strobe qualifies when its enable is set (`error_ceen` for correctable, `error_nceen` for uncorrectable).
- Uncorrectable has priority for `err_req_uncorr`.

Notification FSM:
- IDLE: on a disrupting event, go to REQ. Latch the type.
- REQ: `err_req`=1, type held stable. On `err_ack`, go to GAP. Events arriving in REQ set `pend`. `pend_uncorr` ORs in the event types.
- GAP: lasts one cycle with `err_req`=0. If `pend`, go to REQ with the pending type and clear `pend`; otherwise go to IDLE.
- An event in GAP sets `pend`.
- `err_ack` outside REQ is ignored.

## Timing
- Strobes in cycle c8 update ESR, EAR and FSM at that clock edge. The results are visible in c9, one cycle of latency.
- `err_req` first asserts in c9 for an event from IDLE.
- The request holds for at least 1 cycle. With `err_ack` in the first REQ cycle, the sequence is REQ (1 cycle), GAP (1 cycle), then REQ again if pending.
- Reset values: `errlog_esr`=0, `errlog_ear`=0, `err_req`=0, `err_req_uncorr`=0, FSM=IDLE, `pend`=0.
- Reset mid-REQ drops `err_req` the next cycle and discards any pending event.
- Enables are sampled in the same cycle as the strobe. Changing an enable while in REQ does not withdraw the request.

## Test plan
- Reset, then `decc_scrd_corr_err_c8`=1 with addr 0x1234, `error_ceen`=1. Next cycle: ESR=0x04, EAR=0x1234, `err_req`=1, `err_req_uncorr`=0. Ack gives `err_req`=0 for the GAP cycle and then stays 0.
- spcd correctable with addr A, then spcd uncorrectable with addr B, then a second spcd uncorrectable. Result: ESR=0x23, EAR=B, `err_req` never asserted.
- spcfb correctable and scrd uncorrectable in the same cycle, addr C, both enables set. Result: ESR=0x09, EAR=C, FBE=0, `err_req_uncorr`=1.
- During REQ with no ack, a bscd uncorrectable arrives. Ack next cycle gives 1 GAP cycle, then REQ again with `err_req_uncorr`=1. A second ack returns the FSM to IDLE.
- ESR=0x05; W1C 0x05 in the same cycle as a new scrd correctable strobe. Result: ESR=0x14 (DSC re-set, MEC=1), EAR unchanged.
- Assert `reset` while `err_req`=1 with `pend`=1. Next cycle all outputs are 0, and no request follows.
